alu_op_encoder: RTL and testbench
=================================

// Module: alu_op_encoder
// PURPOSE
//  Inverse of the ALU-op diode matrix: takes the 8-bit ALU control word seen on the
//  ALU stage control bus and re-encodes it to the 4-bit ALUOP that produces it.
//  Feeds the pipeline trace/debug path; a 2-entry output buffer with valid/ready
//  handshakes on both sides tolerates back-pressure from the trace sink.
//  Flags control words that no ALUOP can produce (corrupt or illegal decode).
// PARAMETERS
//  ILLEGAL_OP  4'h0  ALUOP value emitted for an unmatched control word
//  CNT_W       8     width of statistics counters (ALU_ENC_STATS_EN only)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  in_valid      in   1      control word present
//  in_ready      out  1      block can accept a word this cycle
//  in_ctrl       in   8      {CarrySelectB,CarrySelectA,ShiftSelectB,ShiftSelectA,LogicSelect[3:0]}
//  out_valid     out  1      encoded entry available at buffer head
//  out_ready     in   1      sink accepts head entry
//  out_aluop     out  4      encoded ALUOP of head entry
//  out_illegal   out  1      head entry came from an unmatched control word
//  err_sticky    out  1      set by any accepted illegal word
//  err_clr       in   1      synchronous clear of err_sticky
//  stat_words    out  CNT_W  accepted words (ALU_ENC_STATS_EN only)
//  stat_illegal  out  CNT_W  accepted illegal words (ALU_ENC_STATS_EN only)
// BEHAVIOUR
//  - Encode table (in_ctrl -> ALUOP): 00->0 10->1 20->2 0C->3 4C->4 80->5 40->6
//    83->7 43->8 0F->9 38->A 3E->B 36->C 33->D. 00 always encodes to 0 (E/F alias).
//    Any other word: out_aluop=ILLEGAL_OP, out_illegal=1.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Buffer FSM: EMPTY, ONE, FULL (2 entries, FIFO order, no reordering).
//    EMPTY: push->ONE. ONE: push only->FULL, pop only->EMPTY, push+pop->ONE.
//    FULL: pop->ONE; push impossible (in_ready=0).
//  - in_ready = (state!=FULL), registered; out_valid = (state!=EMPTY), registered.
//  - Latency: word accepted at edge N is visible on out_* after edge N (1 cycle)
//    when buffer was EMPTY; otherwise behind older entries.
//  - out_aluop/out_illegal hold the head entry while out_valid=1 & out_ready=0.
//  - err_sticky: set on edge accepting an illegal word; err_clr clears it; set
//    wins over simultaneous err_clr. in_ctrl ignored when no transfer occurs.
//  - Reset (any time, incl. mid-transfer): state=EMPTY, in_ready=1, out_valid=0,
//    out_aluop=0, out_illegal=0, err_sticky=0, counters=0; buffered entries lost.
// CONFIGURATION
//  ALU_ENC_STATS_EN defined: stat_words and stat_illegal present; increment per
//    accepted word / accepted illegal word; saturate at all-ones, never wrap;
//    err_clr also clears stat_illegal (increment wins if simultaneous -> value 1).
//  Undefined: stat_* ports absent, no counter logic; all else identical.
// TESTING
//  1 Reset, out_ready=1, stream all 14 legal words -> ALUOP 0..D, 1-cycle latency,
//    out_illegal=0, in_ready stays 1.
//  2 Hold out_ready=0, push 10,20,0C -> third push stalls (in_ready=0 after 2),
//    then out_ready=1 drains 1,2,3 in order.
//  3 Push 0xFF -> out_aluop=ILLEGAL_OP, out_illegal=1, err_sticky=1; err_clr with
//    concurrent illegal push keeps err_sticky=1.
//  4 In ONE state assert push and pop same cycle -> state stays ONE, order kept.
//  5 Fill buffer, assert reset_n=0 mid-cycle -> out_valid=0, in_ready=1 immediately.
//  6 ALU_ENC_STATS_EN, CNT_W=4: push 20 illegal words -> stat_words=stat_illegal=15.

Source files
------------

// File: rtl/alu_op_encoder_if.sv
// Handshake bus for alu_op_encoder: control-word input side and encoded-entry output side.
interface alu_op_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_aluop;
    logic       out_illegal;

    modport master (
        output in_valid, in_ctrl, out_ready,
        input  in_ready, out_valid, out_aluop, out_illegal
    );

    modport slave (
        input  in_valid, in_ctrl, out_ready,
        output in_ready, out_valid, out_aluop, out_illegal
    );
endinterface

// File: rtl/alu_op_encoder.sv
// Re-encodes ALU-stage control words into 4-bit ALUOPs through a 2-entry output buffer.
// Optional statistics counters are enabled by defining ALU_ENC_STATS_EN.
module alu_op_encoder #(
    parameter logic [3:0] ILLEGAL_OP = 4'h0
`ifdef ALU_ENC_STATS_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_op_encoder_if.slave   bus,
    output logic              err_sticky,
    input  logic              err_clr
`ifdef ALU_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_illegal
`endif
);

    localparam int unsigned ENTRY_W = 5;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} bufStateT;

    bufStateT             state, nextState;
    logic [ENTRY_W-1:0]   headEntry, tailEntry, nextHead, nextTail;
    logic [ENTRY_W-1:0]   encEntry;
    logic [3:0]           encOp;
    logic                 encIllegal;
    logic                 push, pop, nextErr;

    assign push            = bus.in_valid & bus.in_ready;
    assign pop             = bus.out_valid & bus.out_ready;
    assign bus.out_aluop   = headEntry[3:0];
    assign bus.out_illegal = headEntry[4];
    assign encEntry        = {encIllegal, encOp};

    // Inverse of the ALU-op diode matrix; 00 resolves to ALUOP 0 (E/F alias).
    always_comb begin
        encOp      = ILLEGAL_OP;
        encIllegal = 1'b0;
        case (bus.in_ctrl)
            8'h00:   encOp = 4'h0;
            8'h10:   encOp = 4'h1;
            8'h20:   encOp = 4'h2;
            8'h0C:   encOp = 4'h3;
            8'h4C:   encOp = 4'h4;
            8'h80:   encOp = 4'h5;
            8'h40:   encOp = 4'h6;
            8'h83:   encOp = 4'h7;
            8'h43:   encOp = 4'h8;
            8'h0F:   encOp = 4'h9;
            8'h38:   encOp = 4'hA;
            8'h3E:   encOp = 4'hB;
            8'h36:   encOp = 4'hC;
            8'h33:   encOp = 4'hD;
            default: encIllegal = 1'b1;
        endcase
    end

    // Buffer next-state and entry movement; slot order head then tail.
    always_comb begin
        nextState = state;
        nextHead  = headEntry;
        nextTail  = tailEntry;
        nextErr   = err_sticky;
        case (state)
            EMPTY: begin
                if (push) begin
                    nextHead  = encEntry;
                    nextState = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    nextHead = encEntry;
                end else if (push) begin
                    nextTail  = encEntry;
                    nextState = FULL;
                end else if (pop) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    nextHead  = tailEntry;
                    nextState = ONE;
                end
            end
            default: nextState = EMPTY;
        endcase
        if (push && encIllegal) begin
            nextErr = 1'b1;
        end else if (err_clr) begin
            nextErr = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= EMPTY;
            headEntry     <= '0;
            tailEntry     <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            state         <= nextState;
            headEntry     <= nextHead;
            tailEntry     <= nextTail;
            bus.in_ready  <= (nextState != FULL);
            bus.out_valid <= (nextState != EMPTY);
            err_sticky    <= nextErr;
        end
    end

`ifdef ALU_ENC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating counters; a new illegal word beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words   <= '0;
            stat_illegal <= '0;
        end else begin
            if (push && (stat_words != CNT_MAX)) begin
                stat_words <= stat_words + CNT_W'(1);
            end
            if (push && encIllegal) begin
                if (err_clr) begin
                    stat_illegal <= CNT_W'(1);
                end else if (stat_illegal != CNT_MAX) begin
                    stat_illegal <= stat_illegal + CNT_W'(1);
                end
            end else if (err_clr) begin
                stat_illegal <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: randomized and directed words against a table-driven model.
module tb_alu_op_encoder;

    localparam logic [3:0]  ILLEGAL_OP_TB = 4'h0;
    localparam int unsigned TB_CNT_W      = 4;
    localparam int unsigned MAX_WAIT      = 200;

    logic clk;
    logic reset_n;
    logic errSticky;
    logic errClr;
`ifdef ALU_ENC_STATS_EN
    logic [TB_CNT_W-1:0] statWords;
    logic [TB_CNT_W-1:0] statIllegal;
`endif

    alu_op_encoder_if bus ();

`ifdef ALU_ENC_STATS_EN
    alu_op_encoder #(.ILLEGAL_OP(ILLEGAL_OP_TB), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .err_sticky(errSticky), .err_clr(errClr),
        .stat_words(statWords), .stat_illegal(statIllegal)
    );
`else
    alu_op_encoder #(.ILLEGAL_OP(ILLEGAL_OP_TB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .err_sticky(errSticky), .err_clr(errClr)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALUOP n is produced by legalWord[n].
    logic [7:0] legalWord [14] = '{8'h00, 8'h10, 8'h20, 8'h0C, 8'h4C, 8'h80, 8'h40,
                                   8'h83, 8'h43, 8'h0F, 8'h38, 8'h3E, 8'h36, 8'h33};

    logic [4:0] expQ[$];
    int         checks = 0;
    int         errors = 0;
    logic       errModel;
    int         wordsModel;
    int         illModel;
    logic       rndActive;

    function automatic logic [4:0] refEncode(input logic [7:0] c);
        for (int i = 0; i < 14; i++) begin
            if (legalWord[i] == c) return {1'b0, 4'(i)};
        end
        return {1'b1, ILLEGAL_OP_TB};
    endfunction

    function automatic logic [7:0] randomCtrl();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) < 7) return legalWord[$urandom_range(0, 13)];
        return r[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offers one word and records its expected encoding when the DUT takes it.
    task automatic pushWord(input logic [7:0] c);
        logic [4:0] e;
        logic       done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = c;
        for (int k = 0; k < MAX_WAIT && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = refEncode(c);
                expQ.push_back(e);
                wordsModel = (wordsModel < (1 << TB_CNT_W) - 1) ? wordsModel + 1 : wordsModel;
                if (e[4]) begin
                    errModel = 1'b1;
                    illModel = errClr ? 1 : ((illModel < (1 << TB_CNT_W) - 1) ? illModel + 1 : illModel);
                end
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=stalled required=accepted ctrl=%0h", c);
        end
        bus.in_valid = 1'b0;
        bus.in_ctrl  = randomCtrl();
    endtask

    task automatic waitDrain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < MAX_WAIT && !done; k++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares the head entry on every output transfer.
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%0h required=none", bus.out_aluop);
            end else begin
                e = expQ.pop_front();
                chk("out_aluop", 32'(bus.out_aluop), 32'(e[3:0]));
                chk("out_illegal", 32'(bus.out_illegal), 32'(e[4]));
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ctrl  = 8'h00;
        bus.out_ready = 1'b1;
        errClr       = 1'b0;
        errModel     = 1'b0;
        wordsModel   = 0;
        illModel     = 0;
        rndActive    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_aluop", 32'(bus.out_aluop), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_err_sticky", 32'(errSticky), 32'd0);
        @(posedge clk);
        #1;

        // Stream all legal words with a free-running sink: one-cycle latency, no stall.
        for (int i = 0; i < 14; i++) begin
            pushWord(legalWord[i]);
            chk("t1_latency_valid", 32'(bus.out_valid), 32'd1);
            chk("t1_latency_aluop", 32'(bus.out_aluop), 32'(i));
            chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        end
        waitDrain();

        // Back-pressure: third word stalls until the sink drains in order.
        bus.out_ready = 1'b0;
        pushWord(8'h10);
        pushWord(8'h20);
        @(negedge clk);
        chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_full_head", 32'(bus.out_aluop), 32'd1);
        @(posedge clk);
        #1;
        fork
            pushWord(8'h0C);
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitDrain();

        // Illegal word and sticky error; a concurrent clear loses to a new illegal word.
        pushWord(8'hFF);
        waitDrain();
        chk("t3_err_set", 32'(errSticky), 32'(errModel));
        errClr = 1'b1;
        pushWord(8'h01);
        errClr = 1'b0;
        chk("t3_err_clr_vs_set", 32'(errSticky), 32'(errModel));
        errClr = 1'b1;
        @(posedge clk);
        #1 errClr = 1'b0;
        errModel = 1'b0;
        illModel = 0;
        chk("t3_err_cleared", 32'(errSticky), 32'(errModel));
        waitDrain();

        // Simultaneous push and pop from a single-entry buffer.
        bus.out_ready = 1'b0;
        pushWord(8'h38);
        bus.out_ready = 1'b1;
        pushWord(8'h3E);
        bus.out_ready = 1'b0;
        chk("t4_one_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_one_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_one_head", 32'(bus.out_aluop), 32'hB);
        bus.out_ready = 1'b1;
        waitDrain();

        // Randomized traffic with random sink back-pressure.
        rndActive = 1'b1;
        fork
            begin
                while (rndActive) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    pushWord(randomCtrl());
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rndActive = 1'b0;
            end
        join
        bus.out_ready = 1'b1;
        waitDrain();
        chk("rnd_err_sticky", 32'(errSticky), 32'(errModel));

        // Asynchronous reset mid-cycle with a full buffer.
        bus.out_ready = 1'b0;
        pushWord(8'h80);
        pushWord(8'hAA);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_out_aluop", 32'(bus.out_aluop), 32'd0);
        chk("t5_err_sticky", 32'(errSticky), 32'd0);
        expQ.delete();
        errModel   = 1'b0;
        wordsModel = 0;
        illModel   = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

`ifdef ALU_ENC_STATS_EN
        // Saturating statistics with a 4-bit counter.
        for (int i = 0; i < 20; i++) pushWord(8'hFF);
        waitDrain();
        chk("t6_stat_words", 32'(statWords), 32'(wordsModel));
        chk("t6_stat_illegal", 32'(statIllegal), 32'(illModel));
`else
        pushWord(8'h33);
        waitDrain();
`endif
        chk("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
